// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB pipeline stage: default widths and
// the packed layout of one write-back entry.
package mem_wb_stage_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int ZERO_REG       = 0;

    // Entry layout at default widths. The stage packs entries in this field
    // order, so a default-width entry vector casts directly to this type.
    typedef struct packed {
        logic                      reg_write;
        logic [REG_ADDR_W_DEF-1:0] dest;
        logic [DATA_W_DEF-1:0]     wb_data;
    } wb_entry_t;

    // Packed width of one entry for the given data and address widths.
    function automatic int entry_w(input int data_w, input int reg_addr_w);
        return 1 + reg_addr_w + data_w;
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Handshake and data bundle between the MEM stage, the MEM/WB register and
// the write-back consumer. The stage takes the slave side; whatever drives
// the MEM-side inputs and consumes the write-back outputs takes the master side.
interface mem_wb_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    // MEM-side handshake and payload
    logic                  in_valid;
    logic                  in_ready;
    logic                  flush;
    logic                  reg_write_in;
    logic                  mem_to_reg_in;
    logic [DATA_W-1:0]     read_data_in;
    logic [DATA_W-1:0]     address_in;
    logic [REG_ADDR_W-1:0] wb_dest_in;

    // Write-back-side handshake and payload
    logic                  out_valid;
    logic                  out_ready;
    logic                  reg_write_out;
    logic [DATA_W-1:0]     wb_data_out;
    logic [REG_ADDR_W-1:0] wb_dest_out;

    // Register-file forwarding lookup
    logic [REG_ADDR_W-1:0] fwd_addr;
    logic                  fwd_hit;
    logic [DATA_W-1:0]     fwd_data;

    modport slave (
        input  in_valid, flush, reg_write_in, mem_to_reg_in,
               read_data_in, address_in, wb_dest_in,
               out_ready, fwd_addr,
        output in_ready, out_valid, reg_write_out, wb_data_out,
               wb_dest_out, fwd_hit, fwd_data
    );

    modport master (
        output in_valid, flush, reg_write_in, mem_to_reg_in,
               read_data_in, address_in, wb_dest_in,
               out_ready, fwd_addr,
        input  in_ready, out_valid, reg_write_out, wb_data_out,
               wb_dest_out, fwd_hit, fwd_data
    );

endinterface

// File: rtl/mem_wb_stage_wb_entry_reg.sv
// One pipeline entry: a valid bit plus a packed {reg_write, dest, wb_data}
// payload. Clear wins over load. The payload only changes when a valid
// entry is loaded, so an emptied slot keeps its last contents.
module wb_entry_reg
    import mem_wb_stage_pkg::*;
#(
    parameter int W = entry_w(DATA_W_DEF, REG_ADDR_W_DEF)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic         valid_in,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Valid bit and payload register with async reset and clear priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= valid_in;
            if (valid_in) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage with a two-deep FIFO (main + skid). The skid entry
// lets in_ready be a pure register output, which breaks the ready path
// back into MEM. The write-back select happens at capture, so each entry
// already holds its final write-back value.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_wb_stage_if.slave    bus
);

    localparam int EW = entry_w(DATA_W, REG_ADDR_W);

    logic          accept;
    logic          fire;
    logic [EW-1:0] in_entry;

    logic          m_valid;
    logic          m_load;
    logic          m_valid_in;
    logic [EW-1:0] m_d;
    logic [EW-1:0] m_q;

    logic          s_valid;
    logic          s_load;
    logic [EW-1:0] s_q;

    logic          s_hit;
    logic          m_hit;
    logic          fwd_nonzero;

    assign accept   = bus.in_valid & bus.in_ready;
    assign fire     = m_valid & bus.out_ready;
    assign in_entry = {bus.reg_write_in, bus.wb_dest_in,
                       bus.mem_to_reg_in ? bus.read_data_in : bus.address_in};

    // Main entry: refills whenever it is empty or draining. The skid, if
    // occupied, is older than any new input, so it moves up first. While main
    // is empty the skid is always empty, so s_valid alone picks the source.
    assign m_load     = fire | ~m_valid;
    assign m_valid_in = s_valid | accept;
    assign m_d        = s_valid ? s_q : in_entry;

    // Skid entry: on a fire it drains into main (in_ready is low then, so
    // nothing is accepted and it goes empty). Without a fire it captures an
    // input that arrives while main is still occupied.
    assign s_load = fire ? s_valid : (m_valid & accept);

    wb_entry_reg #(.W(EW)) u_main (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (bus.flush),
        .load     (m_load),
        .valid_in (m_valid_in),
        .d        (m_d),
        .valid    (m_valid),
        .q        (m_q)
    );

    wb_entry_reg #(.W(EW)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (bus.flush),
        .load     (s_load),
        .valid_in (accept),
        .d        (in_entry),
        .valid    (s_valid),
        .q        (s_q)
    );

    assign bus.in_ready      = ~s_valid;
    assign bus.out_valid     = m_valid;
    assign bus.reg_write_out = m_valid & m_q[EW-1];
    assign bus.wb_dest_out   = m_q[DATA_W +: REG_ADDR_W];
    assign bus.wb_data_out   = m_q[DATA_W-1:0];

    // Forwarding lookup: r0 never forwards; the younger skid entry wins.
    always_comb begin
        fwd_nonzero = (bus.fwd_addr != {REG_ADDR_W{1'b0}});
        s_hit       = fwd_nonzero & s_valid & s_q[EW-1]
                      & (s_q[DATA_W +: REG_ADDR_W] == bus.fwd_addr);
        m_hit       = fwd_nonzero & m_valid & m_q[EW-1]
                      & (m_q[DATA_W +: REG_ADDR_W] == bus.fwd_addr);
        bus.fwd_hit  = s_hit | m_hit;
        bus.fwd_data = {DATA_W{1'b0}};
        if (s_hit) begin
            bus.fwd_data = s_q[DATA_W-1:0];
        end else if (m_hit) begin
            bus.fwd_data = m_q[DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage. Inputs change 1 time unit after each
// rising edge; outputs are checked at that same point.
module tb_mem_wb_stage;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mem_wb_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

    mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic v, input logic rw, input logic m2r,
                          input logic [31:0] rd, input logic [31:0] addr,
                          input logic [4:0] dest);
        bus.in_valid      = v;
        bus.reg_write_in  = rw;
        bus.mem_to_reg_in = m2r;
        bus.read_data_in  = rd;
        bus.address_in    = addr;
        bus.wb_dest_in    = dest;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        bus.fwd_addr  = 5'd0;
        #12;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (bus.reg_write_out !== 1'b0) begin bad++; $display("FAIL reset_reg_write_out got=%b exp=0", bus.reg_write_out); end
        total++; if (bus.wb_data_out !== 32'h0) begin bad++; $display("FAIL reset_wb_data got=%h exp=0", bus.wb_data_out); end
        total++; if (bus.wb_dest_out !== 5'd0) begin bad++; $display("FAIL reset_wb_dest got=%0d exp=0", bus.wb_dest_out); end
        total++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'h0) begin bad++; $display("FAIL reset_fwd got=%b/%h exp=0/0", bus.fwd_hit, bus.fwd_data); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        logic [31:0] exp_data;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 1'b1, i[0], 32'h1000 + i, 32'h2000 + i, 5'(i + 1));
            tick();
            exp_data = i[0] ? (32'h1000 + i) : (32'h2000 + i);
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, bus.out_valid); end
            total++; if (bus.wb_data_out !== exp_data) begin bad++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, bus.wb_data_out, exp_data); end
            total++; if (bus.wb_dest_out !== 5'(i + 1)) begin bad++; $display("FAIL stream_dest[%0d] got=%0d exp=%0d", i, bus.wb_dest_out, i + 1); end
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, bus.in_ready); end
        end
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_stall_skid();
        bus.out_ready = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_00AA, 5'd3);
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.wb_dest_out !== 5'd3) begin bad++; $display("FAIL stall_a_main got=%b/%0d exp=1/3", bus.out_valid, bus.wb_dest_out); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_ready_a got=%b exp=1", bus.in_ready); end
        set_in(1'b1, 1'b1, 1'b1, 32'h0000_00BB, 32'h0, 5'd4);
        tick();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_skid_full_ready got=%b exp=0", bus.in_ready); end
        total++; if (bus.wb_dest_out !== 5'd3 || bus.wb_data_out !== 32'hAA) begin bad++; $display("FAIL stall_main_hold got=%0d/%h exp=3/aa", bus.wb_dest_out, bus.wb_data_out); end
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        tick();
        total++; if (bus.wb_dest_out !== 5'd3 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_hold2 got=%0d/%b exp=3/0", bus.wb_dest_out, bus.in_ready); end
        bus.out_ready = 1'b1;
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.wb_dest_out !== 5'd4 || bus.wb_data_out !== 32'hBB) begin bad++; $display("FAIL stall_b_out got=%b/%0d/%h exp=1/4/bb", bus.out_valid, bus.wb_dest_out, bus.wb_data_out); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_ready_back got=%b exp=1", bus.in_ready); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stall_empty got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0101, 5'd1);
        tick();
        set_in(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0202, 5'd2);
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_prefill got=%b/%b exp=1/0", bus.out_valid, bus.in_ready); end
        bus.flush = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0909, 5'd9);
        tick();
        bus.flush = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (bus.reg_write_out !== 1'b0) begin bad++; $display("FAIL flush_reg_write got=%b exp=0", bus.reg_write_out); end
        bus.out_ready = 1'b1;
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_forwarding();
        bus.out_ready = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0011, 5'd5);
        tick();
        set_in(1'b1, 1'b1, 1'b1, 32'h0000_0022, 32'h0, 5'd5);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        bus.fwd_addr = 5'd5;
        #1;
        total++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h22) begin bad++; $display("FAIL fwd_skid_priority got=%b/%h exp=1/22", bus.fwd_hit, bus.fwd_data); end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0E0E, 5'd0);
        tick();
        set_in(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0033, 5'd5);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        bus.fwd_addr = 5'd0;
        #1;
        total++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'h0) begin bad++; $display("FAIL fwd_r0 got=%b/%h exp=0/0", bus.fwd_hit, bus.fwd_data); end
        bus.fwd_addr = 5'd5;
        #1;
        total++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h33) begin bad++; $display("FAIL fwd_skid_only got=%b/%h exp=1/33", bus.fwd_hit, bus.fwd_data); end
        bus.fwd_addr = 5'd7;
        #1;
        total++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'h0) begin bad++; $display("FAIL fwd_miss got=%b/%h exp=0/0", bus.fwd_hit, bus.fwd_data); end
        bus.out_ready = 1'b1;
        bus.fwd_addr  = 5'd5;
        tick();
        total++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h33) begin bad++; $display("FAIL fwd_main_only got=%b/%h exp=1/33", bus.fwd_hit, bus.fwd_data); end
        tick();
        total++; if (bus.fwd_hit !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL fwd_drained got=%b/%b exp=0/0", bus.fwd_hit, bus.out_valid); end
    endtask

    task automatic test_reg_write_gating();
        bus.out_ready = 1'b1;
        bus.fwd_addr  = 5'd6;
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0606, 5'd6);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        total++; if (bus.out_valid !== 1'b1 || bus.wb_dest_out !== 5'd6) begin bad++; $display("FAIL gate_present got=%b/%0d exp=1/6", bus.out_valid, bus.wb_dest_out); end
        total++; if (bus.reg_write_out !== 1'b0) begin bad++; $display("FAIL gate_reg_write got=%b exp=0", bus.reg_write_out); end
        total++; if (bus.fwd_hit !== 1'b0) begin bad++; $display("FAIL gate_fwd_hit got=%b exp=0", bus.fwd_hit); end
        tick();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        bus.fwd_addr  = 5'd8;
        set_in(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0808, 5'd8);
        tick();
        set_in(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0909, 5'd9);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        total++; if (bus.in_ready !== 1'b0 || bus.fwd_hit !== 1'b1) begin bad++; $display("FAIL areset_prefill got=%b/%b exp=0/1", bus.in_ready, bus.fwd_hit); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.reg_write_out !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b/%b exp=0/0", bus.out_valid, bus.reg_write_out); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL areset_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (bus.wb_data_out !== 32'h0 || bus.wb_dest_out !== 5'd0) begin bad++; $display("FAIL areset_data got=%h/%0d exp=0/0", bus.wb_data_out, bus.wb_dest_out); end
        total++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'h0) begin bad++; $display("FAIL areset_fwd got=%b/%h exp=0/0", bus.fwd_hit, bus.fwd_data); end
        tick();
        total++; if (bus.reg_write_out !== 1'b0) begin bad++; $display("FAIL areset_held got=%b exp=0", bus.reg_write_out); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (bus.reg_write_out !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL areset_after got=%b/%b exp=0/0", bus.reg_write_out, bus.out_valid); end
        bus.out_ready = 1'b1;
        bus.fwd_addr  = 5'd7;
        set_in(1'b1, 1'b1, 1'b1, 32'h0000_0077, 32'h0000_DEAD, 5'd7);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        total++; if (bus.out_valid !== 1'b1 || bus.reg_write_out !== 1'b1) begin bad++; $display("FAIL areset_first_valid got=%b/%b exp=1/1", bus.out_valid, bus.reg_write_out); end
        total++; if (bus.wb_data_out !== 32'h77 || bus.wb_dest_out !== 5'd7) begin bad++; $display("FAIL areset_first_data got=%h/%0d exp=77/7", bus.wb_data_out, bus.wb_dest_out); end
        total++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h77) begin bad++; $display("FAIL areset_first_fwd got=%b/%h exp=1/77", bus.fwd_hit, bus.fwd_data); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL areset_first_drain got=%b exp=0", bus.out_valid); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush();
        test_forwarding();
        test_reg_write_gating();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised MEM/WB pipeline stage for the MIPS core, with a valid/ready handshake, stall back-pressure and synchronous flush. It holds up to two in-flight instructions: a main register plus a one-entry skid register. This lets the MEM stage hand off without a combinational ready path. It performs the write-back select (memory data vs. ALU address/result) and offers a register-file forwarding lookup across both entries.

## Interface
Parameters:
- DATA_W, 32, width of read data, ALU result and write-back data
- REG_ADDR_W, 5, register-file address width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage can accept; registered, equals ~skid_valid
- flush  in  1  synchronous kill of all held entries
- reg_write_in  in  1  instruction writes the register file
- mem_to_reg_in  in  1  1: write back read_data_in; 0: write back address_in
- read_data_in  in  DATA_W  data-memory read data
- address_in  in  DATA_W  ALU result / memory address
- wb_dest_in  in  REG_ADDR_W  destination register
- out_valid  out  1  main entry valid
- out_ready  in  1  write-back consumer accepts (0 = stall)
- reg_write_out  out  1  main.reg_write AND out_valid
- wb_data_out  out  DATA_W  selected write-back data of main entry
- wb_dest_out  out  REG_ADDR_W  destination of main entry
- fwd_addr  in  REG_ADDR_W  forwarding lookup address
- fwd_hit  out  1  a valid, reg-writing entry targets fwd_addr (never for address 0)
- fwd_data  out  DATA_W  write-back data of the hitting entry

## Operation
- Entry contents: reg_write, dest, wb_data. The select happens at capture: wb_data = mem_to_reg_in ? read_data_in : address_in. Entries are main (M) and skid (S), each with a valid bit.
- accept = in_valid & in_ready; fire = out_valid & out_ready.
- Per-cycle update when flush = 0:
  - fire & S.valid: M <= S; S.valid <= accept; if accept, S <= input. A new accept with S valid cannot occur, since in_ready = 0.
  - fire & !S.valid: M.valid <= accept; M <= input.
  - !fire & !M.valid: M.valid <= accept; M <= input.
  - !fire & M.valid & accept: S <= input; S.valid <= 1.
  - otherwise: hold.
- Flush: M.valid <= 0 and S.valid <= 0. Any same-cycle accept is discarded. Flush has priority over everything, including a fire in that cycle; the consumer still sees the fired entry in that cycle.
- Forwarding (combinational):
  - fwd_hit = (S.valid & S.reg_write & S.dest == fwd_addr) | (M.valid & M.reg_write & M.dest == fwd_addr), forced to 0 when fwd_addr == 0.
  - S (younger) has priority over M for fwd_data. fwd_data is 0 when there is no hit.
- Ordering is strictly FIFO. No entry is duplicated or dropped except by flush.

## Timing
- Reset (async assert, sync-safe deassert): M.valid = S.valid = 0.
  - Outputs: out_valid = 0, in_ready = 1, reg_write_out = 0, wb_data_out = 0, wb_dest_out = 0, fwd_hit = 0, fwd_data = 0.
  - Data registers reset to 0.
- Latency: an input accepted at edge N is on the outputs after edge N when M was empty or fired that cycle. Otherwise it is delayed by one extra stage in S.
- in_ready depends only on registers; there is no in→out combinational path except the fwd lookup.
- Throughput: one per cycle with out_ready held high.
- A stall of k cycles absorbs at most one extra instruction. in_ready drops in the cycle after the skid fills and rises in the cycle after the skid drains.
- Reset mid-operation: all entries are discarded immediately. No reg_write_out pulse occurs during or after reset.

## Structure
- The shared core package (mips_pkg) holds DATA_W/REG_ADDR_W defaults and a packed wb_entry_t struct {reg_write, dest, wb_data}. The stage may also use a localparam ZERO_REG = 0.
- One natural sub-module: wb_entry_reg (a valid-bit plus wb_entry_t register with load/clear), instantiated twice for M and S.
- The forwarding compare is local combinational logic.

## Test plan
- Streaming: 8 back-to-back inputs, out_ready = 1, alternating mem_to_reg → outputs appear one cycle later in order. wb_data is read_data when mem_to_reg = 1, address when 0. in_ready stays 1.
- Stall into skid: out_ready = 0 while inputs A (dest 3) and B (dest 4) arrive.
  - M = A, S = B; in_ready = 0 the following cycle.
  - With out_ready = 1: A then B, with no loss.
- Flush with a full skid: M and S valid, flush = 1 and in_valid = 1 in the same cycle → next cycle out_valid = 0, in_ready = 1, reg_write_out = 0, and the new input is dropped.
- Forwarding priority: M = {dest 5, 0x11}, S = {dest 5, 0x22}, fwd_addr = 5 → fwd_hit = 1, fwd_data = 0x22. With fwd_addr = 0 and an entry targeting r0 → fwd_hit = 0.
- reg_write gating: an entry with reg_write_in = 0 → reg_write_out = 0 and no forward hit on its dest.
- Async reset: assert rst_n = 0 between edges with both entries valid → outputs reach their reset values immediately. After release, the first accepted input emerges correctly.
